mem_arbiter: RTL and testbench

- Single-port memory arbiter and bus sequencer for the reduced86 system.
- Shares one 8-bit-data, 16-bit-address memory port between two requesters: the CPU (read/write, byte or 16-bit word) and the video fetcher (byte reads only).
- Splits each CPU word access into two byte cycles, low byte then high byte.
- Gives video priority, but bounds how long the CPU can be kept waiting.

---
 rtl/mem_arbiter.sv | 258 +++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Single-port memory arbiter and bus sequencer. One 8-bit-data, 16-bit-address
// memory port is shared between the CPU (byte/word, read/write) and the video
// fetcher (byte reads only). CPU word accesses are split into two byte cycles,
// low byte first, then high byte at addr+1 (16-bit wrap). Video has priority,
// but after MAX_WAIT consecutive video grants made while the CPU was waiting,
// the CPU is granted.
//
// Parameters
//   RD_LAT   : cycles from address drive to valid m_i (1..3)
//   MAX_WAIT : max consecutive video grants while c_req is pending
//
// Ports
//   clk25           system clock, all logic on posedge
//   rst_n           asynchronous active-low reset
//   c_req/c_we/c_wide/c_addr/c_wdata : CPU request (level, held until c_ack)
//   c_rdata/c_ack   CPU read data / one-cycle completion pulse
//   v_req/v_addr    video read request (level, held until v_ack)
//   v_rdata/v_ack   video read data / one-cycle completion pulse
//   m_a/m_o/m_w     memory address, write data, write strobe
//   m_i             memory read data
//   busy            high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk25,
    input  logic        rst_n,
    input  logic        c_req,
    input  logic        c_we,
    input  logic        c_wide,
    input  logic [15:0] c_addr,
    input  logic [15:0] c_wdata,
    output logic [15:0] c_rdata,
    output logic        c_ack,
    input  logic        v_req,
    input  logic [15:0] v_addr,
    output logic [7:0]  v_rdata,
    output logic        v_ack,
    output logic [15:0] m_a,
    output logic [7:0]  m_o,
    input  logic [7:0]  m_i,
    output logic        m_w,
    output logic        busy
);

    localparam int            SW         = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_WAIT);
    // Last cycle index of a read byte phase (counter runs 0..RD_LAT-1).
    localparam logic [1:0]    LAT_LAST   = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    state_t        state_reg;
    state_t        state_next;

    // Attributes of the transfer in flight, latched at grant time.
    logic          owner_video_reg;
    logic          we_reg;
    logic          wide_reg;
    logic [7:0]    wdata_hi_reg;

    logic [1:0]    lat_cnt_reg;
    logic [SW-1:0] streak_reg;
    logic [7:0]    lo_byte_reg;

    logic [15:0]   m_a_reg;
    logic [7:0]    m_o_reg;
    logic [15:0]   c_rdata_reg;
    logic [7:0]    v_rdata_reg;

    logic          grant_v;
    logic          grant_c;
    logic          phase_done;
    logic          go_hi;

    // ------------------------------------------------------------------
    // Arbitration: video wins a tie unless the CPU has already watched
    // MAX_WAIT video grants go by. A lone request is always granted.
    // ------------------------------------------------------------------
    assign grant_v = v_req && !(c_req && (streak_reg == STREAK_MAX));
    assign grant_c = c_req && !grant_v;

    // A write byte phase is a single cycle; a read byte phase holds the
    // address for RD_LAT cycles.
    assign phase_done = we_reg || (lat_cnt_reg == LAT_LAST);

    // Only CPU word accesses have a second (high) byte cycle.
    assign go_hi = !owner_video_reg && wide_reg;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Requests are only looked at in IDLE; ACK
    // always returns to IDLE so back-to-back grants see one idle cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (grant_v || grant_c) begin
                    state_next = S_LO;
                end
            end
            S_LO: begin
                if (phase_done) begin
                    state_next = go_hi ? S_HI : S_ACK;
                end
            end
            S_HI: begin
                if (phase_done) begin
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state. m_w is derived from the state so
    // that an asynchronous reset drops the strobe immediately.
    // ------------------------------------------------------------------
    always_comb begin
        busy  = (state_reg != S_IDLE);
        c_ack = (state_reg == S_ACK) && !owner_video_reg;
        v_ack = (state_reg == S_ACK) && owner_video_reg;
        m_w   = ((state_reg == S_LO) || (state_reg == S_HI)) && we_reg;
    end

    // ------------------------------------------------------------------
    // Grant latch and starvation counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            owner_video_reg <= 1'b0;
            we_reg          <= 1'b0;
            wide_reg        <= 1'b0;
            wdata_hi_reg    <= 8'h00;
            streak_reg      <= '0;
        end else if (state_reg == S_IDLE) begin
            if (grant_v) begin
                owner_video_reg <= 1'b1;
                we_reg          <= 1'b0;
                wide_reg        <= 1'b0;
                // Only video grants that overtake a waiting CPU count.
                if (c_req && (streak_reg != STREAK_MAX)) begin
                    streak_reg <= streak_reg + 1'b1;
                end
            end else if (grant_c) begin
                owner_video_reg <= 1'b0;
                we_reg          <= c_we;
                wide_reg        <= c_wide;
                wdata_hi_reg    <= c_wdata[15:8];
                streak_reg      <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte-phase cycle counter: restarts at 0 for every byte phase.
    // ------------------------------------------------------------------
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt_reg <= 2'd0;
        end else if (((state_reg == S_LO) || (state_reg == S_HI)) && !phase_done) begin
            lat_cnt_reg <= lat_cnt_reg + 2'd1;
        end else begin
            lat_cnt_reg <= 2'd0;
        end
    end

    // ------------------------------------------------------------------
    // Memory bus: address and write data are registered and hold their
    // last value while idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            m_a_reg <= 16'h0000;
            m_o_reg <= 8'h00;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (grant_v) begin
                        m_a_reg <= v_addr;
                    end else if (grant_c) begin
                        m_a_reg <= c_addr;
                        if (c_we) begin
                            m_o_reg <= c_wdata[7:0];
                        end
                    end
                end
                S_LO: begin
                    if (phase_done && go_hi) begin
                        m_a_reg <= m_a_reg + 16'd1;   // wraps FFFF -> 0000
                        if (we_reg) begin
                            m_o_reg <= wdata_hi_reg;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read capture. Results are written on the edge entering ACK so the
    // data is already valid while the ack pulse is high; writes and idle
    // cycles leave the read registers untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            lo_byte_reg <= 8'h00;
            c_rdata_reg <= 16'h0000;
            v_rdata_reg <= 8'h00;
        end else if (phase_done && !we_reg) begin
            if (state_reg == S_LO) begin
                if (owner_video_reg) begin
                    v_rdata_reg <= m_i;
                end else if (wide_reg) begin
                    lo_byte_reg <= m_i;
                end else begin
                    c_rdata_reg <= {8'h00, m_i};
                end
            end else if (state_reg == S_HI) begin
                c_rdata_reg <= {m_i, lo_byte_reg};
            end
        end
    end

    assign m_a     = m_a_reg;
    assign m_o     = m_o_reg;
    assign c_rdata = c_rdata_reg;
    assign v_rdata = v_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiters share the clock and reset: u_dut (RD_LAT=1) and u_dut3
// (RD_LAT=3). Each has a byte-wide memory model; the RD_LAT=3 memory only
// presents data for an address two cycles after it was driven. Expected
// results come from a reference byte array, latency formulas and an integer
// streak count.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int MAX_WAIT = 4;

    logic clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    logic rst_n = 1'b1;

    // RD_LAT = 1 instance
    logic        c_req = 1'b0, c_we = 1'b0, c_wide = 1'b0;
    logic [15:0] c_addr = 16'h0, c_wdata = 16'h0;
    logic [15:0] c_rdata;
    logic        c_ack;
    logic        v_req = 1'b0;
    logic [15:0] v_addr = 16'h0;
    logic [7:0]  v_rdata;
    logic        v_ack;
    logic [15:0] m_a;
    logic [7:0]  m_o, m_i;
    logic        m_w, busy;

    // RD_LAT = 3 instance
    logic        c3_req = 1'b0, c3_we = 1'b0, c3_wide = 1'b0;
    logic [15:0] c3_addr = 16'h0, c3_wdata = 16'h0;
    logic [15:0] c3_rdata;
    logic        c3_ack;
    logic        v3_req = 1'b0;
    logic [15:0] v3_addr = 16'h0;
    logic [7:0]  v3_rdata;
    logic        v3_ack;
    logic [15:0] m3_a;
    logic [7:0]  m3_o, m3_i;
    logic        m3_w, busy3;

    mem_arbiter #(.RD_LAT(1), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clk25(clk25), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_wide(c_wide), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ack(c_ack),
        .v_req(v_req), .v_addr(v_addr), .v_rdata(v_rdata), .v_ack(v_ack),
        .m_a(m_a), .m_o(m_o), .m_i(m_i), .m_w(m_w), .busy(busy)
    );

    mem_arbiter #(.RD_LAT(3), .MAX_WAIT(MAX_WAIT)) u_dut3 (
        .clk25(clk25), .rst_n(rst_n),
        .c_req(c3_req), .c_we(c3_we), .c_wide(c3_wide), .c_addr(c3_addr), .c_wdata(c3_wdata),
        .c_rdata(c3_rdata), .c_ack(c3_ack),
        .v_req(v3_req), .v_addr(v3_addr), .v_rdata(v3_rdata), .v_ack(v3_ack),
        .m_a(m3_a), .m_o(m3_o), .m_i(m3_i), .m_w(m3_w), .busy(busy3)
    );

    // ---------------- memory models ----------------
    logic [7:0]  mem1 [0:65535];
    logic [7:0]  mem3 [0:65535];
    logic        pre_we = 1'b0, pre_sel = 1'b0;
    logic [15:0] pre_addr = 16'h0;
    logic [7:0]  pre_data = 8'h0;
    logic [15:0] p3a = 16'h0, p3b = 16'h0;

    always @(posedge clk25) begin
        if (pre_we && !pre_sel) mem1[pre_addr] <= pre_data;
        if (pre_we && pre_sel)  mem3[pre_addr] <= pre_data;
        if (m_w)  mem1[m_a]  <= m_o;
        if (m3_w) mem3[m3_a] <= m3_o;
        p3a <= m3_a;
        p3b <= p3a;
    end

    assign m_i  = mem1[m_a];
    assign m3_i = mem3[p3b];

    // ---------------- write-strobe monitor (RD_LAT=1 bus) ----------------
    typedef struct {
        int          cyc;
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t mw_q[$];
    int  cyc = 0;

    always @(negedge clk25) begin
        cyc <= cyc + 1;
        if (m_w === 1'b1) mw_q.push_back('{cyc, m_a, m_o});
    end

    // ---------------- reference model state ----------------
    logic [7:0]  ref1 [0:65535];
    logic [7:0]  ref3 [0:65535];
    logic [15:0] last_crd1 = 16'h0, last_crd3 = 16'h0;
    logic [7:0]  last_vrd = 8'h0;
    int          model_streak = 0;

    int checks = 0;
    int errors = 0;

    // ---------------- helpers (stimulus only) ----------------
    task automatic preload(input bit sel3, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk25);
        pre_sel  = sel3;
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        if (sel3) ref3[a] = d; else ref1[a] = d;
    endtask

    task automatic cpu_xfer(input bit sel3, input bit we, input bit wide,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            output logic [15:0] rdata, output int lat);
        bit done;
        done  = 1'b0;
        lat   = 0;
        rdata = 16'h0;
        @(negedge clk25);
        if (sel3) begin
            c3_req = 1'b1; c3_we = we; c3_wide = wide; c3_addr = addr; c3_wdata = wdata;
        end else begin
            c_req = 1'b1; c_we = we; c_wide = wide; c_addr = addr; c_wdata = wdata;
        end
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk25);
            if ((sel3 ? c3_ack : c_ack) === 1'b1) begin
                lat   = k;
                rdata = sel3 ? c3_rdata : c_rdata;
                done  = 1'b1;
                if (sel3) c3_req = 1'b0; else c_req = 1'b0;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL cpu_timeout: no c_ack within 60 cycles (dut%0d addr=%h), ack required", sel3 ? 3 : 1, addr);
            c_req = 1'b0; c3_req = 1'b0;
        end
    endtask

    task automatic video_xfer(input logic [15:0] addr, output logic [7:0] rdata, output int lat);
        bit done;
        done  = 1'b0;
        lat   = 0;
        rdata = 8'h0;
        @(negedge clk25);
        v_req  = 1'b1;
        v_addr = addr;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk25);
            if (v_ack === 1'b1) begin
                lat   = k;
                rdata = v_rdata;
                done  = 1'b1;
                v_req = 1'b0;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL video_timeout: no v_ack within 60 cycles (addr=%h), ack required", addr);
            v_req = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk25);
        #1;
        checks++;
        if ({c_rdata, v_rdata} !== 24'h0) begin
            errors++; $display("FAIL reset_rdata1: got %h, expected 000000", {c_rdata, v_rdata});
        end
        checks++;
        if ({m_a, m_o, m_w} !== 25'h0) begin
            errors++; $display("FAIL reset_bus1: got m_a=%h m_o=%h m_w=%b, expected 0000/00/0", m_a, m_o, m_w);
        end
        checks++;
        if ({c_ack, v_ack, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_hs1: got c_ack/v_ack/busy=%b, expected 000", {c_ack, v_ack, busy});
        end
        checks++;
        if ({c3_rdata, v3_rdata} !== 24'h0) begin
            errors++; $display("FAIL reset_rdata3: got %h, expected 000000", {c3_rdata, v3_rdata});
        end
        checks++;
        if ({m3_a, m3_o, m3_w} !== 25'h0) begin
            errors++; $display("FAIL reset_bus3: got m_a=%h m_o=%h m_w=%b, expected 0000/00/0", m3_a, m3_o, m3_w);
        end
        checks++;
        if ({c3_ack, v3_ack, busy3} !== 3'b000) begin
            errors++; $display("FAIL reset_hs3: got c_ack/v_ack/busy=%b, expected 000", {c3_ack, v3_ack, busy3});
        end
    endtask

    task automatic test_cpu_byte_read();
        logic [15:0] rd;
        int lat, w0;
        w0 = mw_q.size();
        cpu_xfer(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, rd, lat);
        $display("xfer cpu byte read  dut1 addr=1234 rdata=%h lat=%0d", rd, lat);
        checks++;
        if (lat != 2) begin errors++; $display("FAIL byte_read_lat: got %0d, expected 2", lat); end
        checks++;
        if (rd !== 16'h005A) begin errors++; $display("FAIL byte_read_data: got %h, expected 005a", rd); end
        checks++;
        if (mw_q.size() != w0) begin
            errors++; $display("FAIL byte_read_no_write: got %0d m_w cycles, expected 0", mw_q.size() - w0);
        end
        last_crd1    = 16'h005A;
        model_streak = 0;
    endtask

    task automatic test_word_write_wrap();
        logic [15:0] rd;
        int lat, w0;
        w0 = mw_q.size();
        cpu_xfer(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hBEEF, rd, lat);
        $display("xfer cpu word write dut1 addr=ffff wdata=beef lat=%0d", lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL word_write_lat: got %0d, expected 3", lat); end
        checks++;
        if (mw_q.size() - w0 != 2) begin
            errors++; $display("FAIL word_write_count: got %0d m_w cycles, expected 2", mw_q.size() - w0);
        end
        if (mw_q.size() >= w0 + 2) begin
            checks++;
            if (mw_q[w0].a !== 16'hFFFF || mw_q[w0].d !== 8'hEF) begin
                errors++; $display("FAIL word_write_lo: got %h/%h, expected ffff/ef", mw_q[w0].a, mw_q[w0].d);
            end
            checks++;
            if (mw_q[w0+1].a !== 16'h0000 || mw_q[w0+1].d !== 8'hBE) begin
                errors++; $display("FAIL word_write_hi: got %h/%h, expected 0000/be", mw_q[w0+1].a, mw_q[w0+1].d);
            end
            checks++;
            if (mw_q[w0+1].cyc != mw_q[w0].cyc + 1) begin
                errors++; $display("FAIL word_write_consecutive: got gap %0d, expected 1", mw_q[w0+1].cyc - mw_q[w0].cyc);
            end
        end
        checks++;
        if (rd !== last_crd1) begin errors++; $display("FAIL word_write_rdata_hold: got %h, expected %h", rd, last_crd1); end
        ref1[16'hFFFF] = 8'hEF;
        ref1[16'h0000] = 8'hBE;
        model_streak   = 0;
    endtask

    task automatic test_rdlat3_word_read();
        logic [15:0] rd;
        logic [15:0] ma_seen [6];
        logic [15:0] exp_a;
        int lat;
        bit done;
        done = 1'b0; lat = 0; rd = 16'h0;
        @(negedge clk25);
        c3_req = 1'b1; c3_we = 1'b0; c3_wide = 1'b1; c3_addr = 16'h0100;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk25);
            if (k <= 6) ma_seen[k-1] = m3_a;
            if (c3_ack === 1'b1) begin lat = k; rd = c3_rdata; done = 1'b1; c3_req = 1'b0; end
        end
        c3_req = 1'b0;
        $display("xfer cpu word read  dut3 addr=0100 rdata=%h lat=%0d", rd, lat);
        checks++;
        if (lat != 7) begin errors++; $display("FAIL rdlat3_lat: got %0d, expected 7", lat); end
        checks++;
        if (rd !== 16'h1234) begin errors++; $display("FAIL rdlat3_data: got %h, expected 1234", rd); end
        for (int i = 0; i < 6; i++) begin
            exp_a = (i < 3) ? 16'h0100 : 16'h0101;
            checks++;
            if (ma_seen[i] !== exp_a) begin
                errors++; $display("FAIL rdlat3_addr[%0d]: got %h, expected %h", i, ma_seen[i], exp_a);
            end
        end
        last_crd3 = 16'h1234;
    endtask

    task automatic test_video();
        logic [7:0] vd;
        int lat;
        video_xfer(16'hB800, vd, lat);
        $display("xfer video read     dut1 addr=b800 rdata=%h lat=%0d", vd, lat);
        checks++;
        if (lat != 2) begin errors++; $display("FAIL video_lat: got %0d, expected 2", lat); end
        checks++;
        if (vd !== 8'h41) begin errors++; $display("FAIL video_data: got %h, expected 41", vd); end
        checks++;
        if (c_rdata !== last_crd1) begin errors++; $display("FAIL video_crdata_hold: got %h, expected %h", c_rdata, last_crd1); end
        last_vrd = 8'h41;
    endtask

    task automatic test_arbitration();
        logic [15:0] ca, va;
        int  n, streak;
        bit  exp_c;
        ca = 16'hFFF4; va = 16'hFFF8;
        n = 0; streak = model_streak;
        @(negedge clk25);
        c_req = 1'b1; c_we = 1'b0; c_wide = 1'b0; c_addr = ca;
        v_req = 1'b1; v_addr = va;
        for (int k = 0; k < 200 && n < 10; k++) begin
            @(negedge clk25);
            if (c_ack === 1'b1 || v_ack === 1'b1) begin
                exp_c = (streak == MAX_WAIT);
                if (exp_c) streak = 0; else streak++;
                $display("xfer arbitration grant %0d winner=%s", n, (c_ack === 1'b1) ? "C" : "V");
                checks++;
                if (c_ack !== exp_c || v_ack !== !exp_c) begin
                    errors++; $display("FAIL grant_order[%0d]: got %s, expected %s", n,
                                       (c_ack === 1'b1) ? "C" : "V", exp_c ? "C" : "V");
                end
                checks++;
                if (exp_c && c_rdata !== {8'h00, ref1[ca]}) begin
                    errors++; $display("FAIL arb_cdata[%0d]: got %h, expected %h", n, c_rdata, {8'h00, ref1[ca]});
                end else if (!exp_c && v_rdata !== ref1[va]) begin
                    errors++; $display("FAIL arb_vdata[%0d]: got %h, expected %h", n, v_rdata, ref1[va]);
                end
                n++;
                if (n == 10) begin c_req = 1'b0; v_req = 1'b0; end
            end
        end
        c_req = 1'b0; v_req = 1'b0;
        if (n < 10) begin
            checks++; errors++;
            $display("FAIL arb_timeout: got %0d grants, expected 10", n);
        end
        model_streak = streak;
        last_crd1    = {8'h00, ref1[ca]};
        last_vrd     = ref1[va];
    endtask

    task automatic test_reset_mid();
        logic [15:0] a, a1, wd;
        bit hit, seen_ack, done;
        int w0, lat;
        a = 16'hFFF6; a1 = a + 16'd1;
        wd = 16'($urandom);
        hit = 1'b0; seen_ack = 1'b0; done = 1'b0; lat = 0;
        @(negedge clk25);
        c_req = 1'b1; c_we = 1'b1; c_wide = 1'b1; c_addr = a; c_wdata = wd;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk25);
            if (c_ack === 1'b1) seen_ack = 1'b1;
            if (m_w === 1'b1 && m_a === a1) hit = 1'b1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL reset_mid_reach_hi: got no high-byte write, expected one"); end
        #5 rst_n = 1'b0;
        #1;
        checks++;
        if (m_w !== 1'b0) begin errors++; $display("FAIL reset_mid_mw: got %b, expected 0", m_w); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b, expected 0", busy); end
        checks++;
        if ({m_a, m_o} !== 24'h0) begin errors++; $display("FAIL reset_mid_bus: got %h/%h, expected 0000/00", m_a, m_o); end
        checks++;
        if (u_dut.streak_reg !== '0) begin errors++; $display("FAIL reset_mid_streak: got %0d, expected 0", u_dut.streak_reg); end
        @(negedge clk25);
        checks++;
        if (seen_ack || c_ack !== 1'b0) begin errors++; $display("FAIL reset_mid_noack: got ack, expected none"); end
        w0 = mw_q.size();
        rst_n = 1'b1;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk25);
            if (c_ack === 1'b1) begin lat = k; done = 1'b1; c_req = 1'b0; end
        end
        c_req = 1'b0;
        $display("xfer cpu word write dut1 addr=%h wdata=%h restarted after reset lat=%0d", a, wd, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL reset_mid_restart_lat: got %0d, expected 3", lat); end
        checks++;
        if (mw_q.size() - w0 != 2) begin
            errors++; $display("FAIL reset_mid_restart_count: got %0d writes, expected 2", mw_q.size() - w0);
        end else begin
            checks++;
            if (mw_q[w0].a !== a || mw_q[w0].d !== wd[7:0] || mw_q[w0+1].a !== a1 || mw_q[w0+1].d !== wd[15:8]) begin
                errors++; $display("FAIL reset_mid_restart_bytes: got %h/%h %h/%h, expected %h/%h %h/%h",
                                   mw_q[w0].a, mw_q[w0].d, mw_q[w0+1].a, mw_q[w0+1].d, a, wd[7:0], a1, wd[15:8]);
            end
        end
        ref1[a]  = wd[7:0];
        ref1[a1] = wd[15:8];
        last_crd1 = 16'h0; last_crd3 = 16'h0; last_vrd = 8'h0;
        model_streak = 0;
    endtask

    task automatic test_random();
        int op, rl, lat, exp_lat;
        bit s3, we, wide;
        logic [15:0] a, a1, wd, rd, exp_rd, hold;
        logic [7:0]  vd, lo, hi;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 4);
            s3 = (op != 4) && ($urandom_range(0, 1) == 1);
            rl = s3 ? 3 : 1;
            a  = 16'hFFF0 + 16'($urandom_range(0, 30));
            a1 = a + 16'd1;
            wd = 16'($urandom);
            if (op == 4) begin
                video_xfer(a, vd, lat);
                $display("xfer rand %0d video read dut1 addr=%h rdata=%h lat=%0d", i, a, vd, lat);
                checks++;
                if (lat != 2) begin errors++; $display("FAIL rand_vlat[%0d]: got %0d, expected 2", i, lat); end
                checks++;
                if (vd !== ref1[a]) begin errors++; $display("FAIL rand_vdata[%0d]: got %h, expected %h", i, vd, ref1[a]); end
                checks++;
                if (c_rdata !== last_crd1) begin errors++; $display("FAIL rand_crdata_hold[%0d]: got %h, expected %h", i, c_rdata, last_crd1); end
                last_vrd = ref1[a];
            end else begin
                we   = (op >= 2);
                wide = (op == 1) || (op == 3);
                lo   = s3 ? ref3[a]  : ref1[a];
                hi   = s3 ? ref3[a1] : ref1[a1];
                exp_rd  = wide ? {hi, lo} : {8'h00, lo};
                exp_lat = we ? (wide ? 3 : 2) : (wide ? 1 + 2 * rl : 1 + rl);
                hold    = s3 ? last_crd3 : last_crd1;
                cpu_xfer(s3, we, wide, a, wd, rd, lat);
                $display("xfer rand %0d cpu %s %s dut%0d addr=%h wdata=%h rdata=%h lat=%0d", i,
                         wide ? "word" : "byte", we ? "write" : "read", rl, a, wd, rd, lat);
                checks++;
                if (lat != exp_lat) begin errors++; $display("FAIL rand_lat[%0d]: got %0d, expected %0d", i, lat, exp_lat); end
                checks++;
                if (we) begin
                    if (rd !== hold) begin errors++; $display("FAIL rand_wr_hold[%0d]: got %h, expected %h", i, rd, hold); end
                    if (s3) begin ref3[a] = wd[7:0]; if (wide) ref3[a1] = wd[15:8]; end
                    else    begin ref1[a] = wd[7:0]; if (wide) ref1[a1] = wd[15:8]; end
                end else begin
                    if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d]: got %h, expected %h", i, rd, exp_rd); end
                    if (s3) last_crd3 = exp_rd; else last_crd1 = exp_rd;
                end
                if (!s3) model_streak = 0;
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        #1 rst_n = 1'b0;
        for (int i = 0; i < 32; i++) begin
            preload(1'b0, 16'hFFF0 + 16'(i), 8'($urandom));
            preload(1'b1, 16'hFFF0 + 16'(i), 8'($urandom));
        end
        preload(1'b0, 16'h1234, 8'h5A);
        preload(1'b0, 16'hB800, 8'h41);
        preload(1'b1, 16'h0100, 8'h34);
        preload(1'b1, 16'h0101, 8'h12);
        @(negedge clk25);
        pre_we = 1'b0;
        test_reset();
        @(negedge clk25);
        rst_n = 1'b1;
        test_cpu_byte_read();
        test_word_write_wrap();
        test_rdlat3_word_read();
        test_video();
        test_arbitration();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk25);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(4_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
